uart_tx_scheduler: RTL and testbench

- Shares one UART transmit controller between NUM_REQ byte-stream requesters, e.g. the AXI-lite write path, a debug/loopback source and a status reporter.
- Arbitrates round-robin with packet locking: a granted requester keeps the transmitter until it sends a byte flagged last, or until a lock timeout expires.
- Sequences the transmitter: one tx_enable pulse per byte, tx_data held stable, then waits for tx_done.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rr_arbiter.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler and its helpers.
//   sched_state_t : scheduler FSM states (S_GAP only reachable with UART_TX_GAP_EN)
//   UART_BYTE_W   : width of one transmitted byte
//   grant_w()     : index width needed to name one of n requesters (at least 1)
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WAIT   = 3'd2,
        S_LOCKED = 3'd3,
        S_GAP    = 3'd4
    } sched_state_t;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr_i,
// wrapping around to index 0.
//   req_i       : request vector
//   rr_ptr_i    : highest-priority index this round (must be < NUM_REQ)
//   winner_o    : index of the selected request (0 when none)
//   any_valid_o : at least one request is set
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int GW = grant_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [GW-1:0]      rr_ptr_i,
    output logic [GW-1:0]      winner_o,
    output logic               any_valid_o
);

    // Scan from lowest to highest priority so the last hit written is the
    // closest one at or above the pointer.
    always_comb begin
        winner_o    = {GW{1'b0}};
        any_valid_o = |req_i;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            winner_o = req_i[(int'(rr_ptr_i) + i) % NUM_REQ]
                     ? GW'((int'(rr_ptr_i) + i) % NUM_REQ)
                     : winner_o;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration with packet locking: a grantee keeps the
// transmitter until it sends a byte flagged last or stalls LOCK_TIMEOUT
// cycles while locked. Each byte gets a one-cycle tx_enable, tx_data held
// until tx_done.
// Optional feature macro: UART_TX_GAP_EN inserts GAP_CYCLES idle cycles
// (S_GAP) after every tx_done.
// Ports:
//   clk, Resetn          : clock, asynchronous active-low reset
//   req_valid/data/last  : per-requester byte stream (byte i at [8i+7:8i])
//   req_ready            : one-hot acceptance, high only in S_ACCEPT
//   clear                : synchronous abort of lock/arbitration
//   tx_enable, tx_data   : start pulse and byte to the transmitter
//   tx_done              : transmitter finished the byte
//   grant_id             : current/last grantee
//   busy                 : FSM not idle
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int LOCK_TIMEOUT = 1023,
    parameter int GAP_CYCLES   = 16,
    localparam int GW = grant_w(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           Resetn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           clear,
    output logic                           tx_enable,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_done,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    sched_state_t           state_q, state_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]          grant_id_q, grant_id_d;
    logic                   tx_enable_q, tx_enable_d;
    logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
    logic                   last_q, last_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NUM_REQ-1:0]     req_ready_s;
    logic [GW-1:0]          winner_s;
    logic                   any_valid_s;
    logic [GW-1:0]          next_ptr_s;

`ifdef UART_TX_GAP_EN
    localparam int GCW = $clog2(GAP_CYCLES + 1);
    logic [GCW-1:0]         gap_q, gap_d;
`endif

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .winner_o    (winner_s),
        .any_valid_o (any_valid_s)
    );

    // Pointer position just past the current grantee, wrapping to 0.
    always_comb begin
        if (grant_id_q == GW'(NUM_REQ - 1)) begin
            next_ptr_s = {GW{1'b0}};
        end else begin
            next_ptr_s = grant_id_q + GW'(1'b1);
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= {GW{1'b0}};
            grant_id_q  <= {GW{1'b0}};
            tx_enable_q <= 1'b0;
            tx_data_q   <= {UART_BYTE_W{1'b0}};
            last_q      <= 1'b0;
            timer_q     <= {TW{1'b0}};
`ifdef UART_TX_GAP_EN
            gap_q       <= {GCW{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
            last_q      <= last_d;
            timer_q     <= timer_d;
`ifdef UART_TX_GAP_EN
            gap_q       <= gap_d;
`endif
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        tx_enable_d = 1'b0;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        timer_d     = timer_q;
        req_ready_s = {NUM_REQ{1'b0}};
`ifdef UART_TX_GAP_EN
        gap_d       = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else if (any_valid_s) begin
                    grant_id_d = winner_s;
                    state_d    = S_ACCEPT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCEPT: begin
                // clear wins over the handshake: no ready, nothing captured.
                if (clear) begin
                    state_d = S_IDLE;
                end else begin
                    req_ready_s[grant_id_q] = 1'b1;
                    tx_data_d   = req_data[int'(grant_id_q) * UART_BYTE_W +: UART_BYTE_W];
                    last_d      = req_last[grant_id_q];
                    tx_enable_d = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // clear cannot abort the byte on the wire; it just ends the packet.
                if (clear) begin
                    last_d = 1'b1;
                end else begin
                    last_d = last_q;
                end
                if (tx_done) begin
`ifdef UART_TX_GAP_EN
                    state_d = S_GAP;
                    gap_d   = {GCW{1'b0}};
`else
                    if (last_q || clear) begin
                        rr_ptr_d = next_ptr_s;
                        state_d  = S_IDLE;
                    end else begin
                        timer_d = {TW{1'b0}};
                        state_d = S_LOCKED;
                    end
`endif
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_LOCKED: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else if (req_valid[grant_id_q]) begin
                    state_d = S_ACCEPT;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    // Stalled grantee loses the lock; others get a turn.
                    rr_ptr_d = next_ptr_s;
                    timer_d  = {TW{1'b0}};
                    state_d  = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1'b1);
                end
            end
`ifdef UART_TX_GAP_EN
            S_GAP: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else if (gap_q == GCW'(GAP_CYCLES - 1)) begin
                    if (last_q) begin
                        rr_ptr_d = next_ptr_s;
                        state_d  = S_IDLE;
                    end else begin
                        timer_d = {TW{1'b0}};
                        state_d = S_LOCKED;
                    end
                end else begin
                    gap_d = gap_q + GCW'(1'b1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = req_ready_s;
    assign tx_enable = tx_enable_q;
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int NREQ = 3;
    localparam int LT   = 8;
    localparam int GAP  = 16;
`ifdef UART_TX_GAP_EN
    localparam int GAP_EXP = GAP;
`else
    localparam int GAP_EXP = 0;
`endif

    logic            clk = 1'b0;
    logic            Resetn = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0] req_last = '0;
    logic [NREQ-1:0] req_ready;
    logic            clear = 1'b0;
    logic            tx_enable;
    logic [7:0]      tx_data;
    logic            tx_done = 1'b0;
    logic [1:0]      grant_id;
    logic            busy;

    int checks = 0;
    int fails  = 0;
    int cyc = 0;
    int en_cnt = 0;
    int done_cyc = 0;
    int gap_meas = 0;
    int en_base;

    uart_tx_scheduler #(
        .NUM_REQ      (NREQ),
        .LOCK_TIMEOUT (LT),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk       (clk),
        .Resetn    (Resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .clear     (clear),
        .tx_enable (tx_enable),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter, tx_enable count and tx_done -> tx_enable spacing.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_enable) begin
            en_cnt   <= en_cnt + 1;
            gap_meas <= cyc - done_cyc;
        end
        if (tx_done) done_cyc <= cyc;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic gap_wait();
`ifdef UART_TX_GAP_EN
        for (int k = 0; k < GAP; k++) begin
            check("gap_ready", {29'd0, req_ready}, 32'd0);
            check("gap_txen", {31'd0, tx_enable}, 32'd0);
            tick();
        end
`endif
    endtask

    // One byte from a cycle in which the FSM will move to S_ACCEPT next.
    task automatic xfer(input int g, input logic [7:0] d, input logic exp_busy);
        tick();
        check("ready", {29'd0, req_ready}, 32'(1 << g));
        check("grant", {30'd0, grant_id}, 32'(g));
        check("txen_early", {31'd0, tx_enable}, 32'd0);
        tick();
        req_valid[g] = 1'b0;
        check("txen", {31'd0, tx_enable}, 32'd1);
        check("txdata", {24'd0, tx_data}, {24'd0, d});
        check("ready_wait", {29'd0, req_ready}, 32'd0);
        tick();
        check("txen_pulse", {31'd0, tx_enable}, 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        gap_wait();
        check("busy_after", {31'd0, busy}, {31'd0, exp_busy});
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
    endtask

    initial begin
        // Reset values
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_txen", {31'd0, tx_enable}, 32'd0);
        check("rst_txdata", {24'd0, tx_data}, 32'd0);
        check("rst_ready", {29'd0, req_ready}, 32'd0);
        check("rst_grant", {30'd0, grant_id}, 32'd0);
        Resetn = 1'b1;
        tick();

        // Single byte from requester 1
        req_data[15:8] = 8'hA5;
        req_last = 3'b010;
        req_valid = 3'b010;
        xfer(1, 8'hA5, 1'b0);
        // rr_ptr now 2: requester 2 beats 0
        req_data[7:0] = 8'h11;
        req_data[23:16] = 8'h33;
        req_last = 3'b111;
        req_valid = 3'b101;
        xfer(2, 8'h33, 1'b0);
        xfer(0, 8'h11, 1'b0);

        // Contention: order 0,1,2,0
        do_reset();
        req_data = {8'hC2, 8'hC1, 8'hC0};
        req_last = 3'b111;
        req_valid = 3'b111;
        en_base = en_cnt;
        xfer(0, 8'hC0, 1'b0);
        req_valid[0] = 1'b1;
        xfer(1, 8'hC1, 1'b0);
        xfer(2, 8'hC2, 1'b0);
        xfer(0, 8'hC0, 1'b0);
        check("en_count", 32'(en_cnt - en_base), 32'd4);

        // Packet lock: req0 three bytes while req2 waits
        do_reset();
        req_data = {8'hE2, 8'h00, 8'hB0};
        req_last = 3'b100;
        req_valid = 3'b101;
        xfer(0, 8'hB0, 1'b1);
        req_data[7:0] = 8'hB1;
        req_valid[0] = 1'b1;
        xfer(0, 8'hB1, 1'b1);
        check("done_to_en", 32'(gap_meas), 32'(3 + GAP_EXP));
        req_data[7:0] = 8'hB2;
        req_last[0] = 1'b1;
        req_valid[0] = 1'b1;
        xfer(0, 8'hB2, 1'b0);
        xfer(2, 8'hE2, 1'b0);

        // Lock timeout: req0 stalls, req1 waits LT cycles in S_LOCKED
        req_data[7:0] = 8'h5A;
        req_last = 3'b000;
        req_valid = 3'b001;
        xfer(0, 8'h5A, 1'b1);
        req_data[15:8] = 8'h6B;
        req_last = 3'b010;
        req_valid = 3'b010;
        for (int k = 1; k < LT; k++) begin
            tick();
            check("lock_busy", {31'd0, busy}, 32'd1);
            check("lock_ready", {29'd0, req_ready}, 32'd0);
        end
        tick();
        check("lock_expired", {31'd0, busy}, 32'd0);
        xfer(1, 8'h6B, 1'b0);

        // clear in S_WAIT mid-packet, then in S_ACCEPT
        req_data[7:0] = 8'h77;
        req_last = 3'b000;
        req_valid = 3'b001;
        tick();
        check("clr_ready", {29'd0, req_ready}, 32'd1);
        tick();
        check("clr_txdata", {24'd0, tx_data}, 32'h77);
        req_data[7:0] = 8'h78;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_wait_busy", {31'd0, busy}, 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        gap_wait();
        check("clr_wait_idle", {31'd0, busy}, 32'd0);
        tick();
        clear = 1'b1;
        #1;
        check("clr_acc_ready", {29'd0, req_ready}, 32'd0);
        check("clr_acc_busy", {31'd0, busy}, 32'd1);
        tick();
        clear = 1'b0;
        check("clr_acc_idle", {31'd0, busy}, 32'd0);
        xfer(0, 8'h78, 1'b1);
        // clear in S_LOCKED
        clear = 1'b1;
        #1;
        check("clr_lock_ready", {29'd0, req_ready}, 32'd0);
        tick();
        clear = 1'b0;
        check("clr_lock_idle", {31'd0, busy}, 32'd0);

        // Reset mid-operation (mid-gap when the gap is built in)
        req_data[23:16] = 8'hC3;
        req_last = 3'b000;
        req_valid = 3'b100;
        tick();
        check("mid_grant", {30'd0, grant_id}, 32'd2);
        tick();
        req_valid = 3'b000;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
`ifdef UART_TX_GAP_EN
        repeat (5) tick();
`endif
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        Resetn = 1'b0;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_txdata", {24'd0, tx_data}, 32'd0);
        check("mid_grant_rst", {30'd0, grant_id}, 32'd0);
        check("mid_txen", {31'd0, tx_enable}, 32'd0);
        check("mid_ready", {29'd0, req_ready}, 32'd0);
        tick();
        Resetn = 1'b1;
        req_data[7:0] = 8'h42;
        req_last = 3'b001;
        req_valid = 3'b001;
        xfer(0, 8'h42, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
